// File: rtl/dac_out_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel DAC output stage.
package dac_out_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROC  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [1:0] SER_IDLE  = 2'd0;
  localparam logic [1:0] SER_SHIFT = 2'd1;
  localparam logic [1:0] SER_GAP   = 2'd2;

  function automatic int frame_w(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction

  // Pull a signed sample toward zero by ns without crossing it.
  function automatic int sat_sub(input int y, input int ns);
    if (y > 0) return (y > ns) ? y - ns : 0;
    else if (y < 0) return (-y > ns) ? y + ns : 0;
    else return 0;
  endfunction

  function automatic int shift_sat(input int y, input int sh, input int w);
    longint v;
    longint hi;
    longint lo;
    v  = longint'(y) <<< sh;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

endpackage

// File: rtl/dac_output_multi_hpf_serializer.sv
// Self-timed SPI engine: shared SYNC/SCLK, one shift register and DIN per DAC.
module dac_spi_serializer
  import dac_out_pkg::*;
#(
  parameter int NUM_DAC  = 8,
  parameter int FRAME_W  = 24,
  parameter int SCLK_DIV = 2,
  parameter int CH_W     = 3
) (
  input  logic               dataclk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [CH_W-1:0]    load_ch,
  input  logic [FRAME_W-1:0] load_word,
  input  logic               start,
  output logic               dac_sync,
  output logic               dac_sclk,
  output logic [NUM_DAC-1:0] dac_din,
  output logic               in_gap,
  output logic               done
);

  localparam int CNT_W = $clog2(2 * SCLK_DIV);
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  logic [1:0]         ser_state;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shreg [NUM_DAC];
  logic               shift_now;

  // A new bit goes out on every SCLK rise: the first one on start, the rest at each bit boundary.
  always_comb begin
    shift_now = 1'b0;
    if (ser_state == SER_IDLE && start) shift_now = 1'b1;
    if (ser_state == SER_SHIFT && cnt == CNT_LAST && bit_cnt != BIT_LAST) shift_now = 1'b1;
  end

  assign in_gap = (ser_state == SER_GAP);
  assign done   = (ser_state == SER_GAP) && (cnt == CNT_HALF);

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      ser_state <= SER_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      dac_sync  <= 1'b1;
      dac_sclk  <= 1'b0;
      dac_din   <= '0;
      for (int i = 0; i < NUM_DAC; i++) shreg[i] <= '0;
    end else begin
      if (load) shreg[load_ch] <= load_word;
      if (shift_now) begin
        dac_sclk <= 1'b1;
        cnt      <= '0;
        for (int i = 0; i < NUM_DAC; i++) begin
          dac_din[i] <= shreg[i][FRAME_W-1];
          shreg[i]   <= shreg[i] << 1;
        end
      end
      case (ser_state)
        SER_IDLE: if (start) begin
          ser_state <= SER_SHIFT;
          dac_sync  <= 1'b0;
          bit_cnt   <= '0;
        end
        SER_SHIFT: if (cnt == CNT_LAST) begin
          if (bit_cnt == BIT_LAST) begin
            ser_state <= SER_GAP;
            dac_sync  <= 1'b1;
            dac_sclk  <= 1'b0;
            dac_din   <= '0;
            cnt       <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_HALF) dac_sclk <= 1'b0;
        end
        SER_GAP: if (cnt == CNT_HALF) ser_state <= SER_IDLE;
                 else cnt <= cnt + 1'b1;
        default: ser_state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dac_output_multi_hpf.sv
// Multi-DAC output stage: shared HPF / noise / gain pipeline feeding a common SPI serializer.
module dac_output_multi_hpf
  import dac_out_pkg::*;
#(
  parameter int NUM_DAC  = 8,
  parameter int DATA_W   = 16,
  parameter int CMD_W    = 8,
  parameter int SCLK_DIV = 2
) (
  input  logic                      dataclk,
  input  logic                      reset_n,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [NUM_DAC*DATA_W-1:0] DAC_input,
  input  logic [NUM_DAC-1:0]        DAC_en,
  input  logic [3*NUM_DAC-1:0]      gain,
  input  logic [6:0]                noise_suppress,
  input  logic [15:0]               HPF_coefficient,
  input  logic                      HPF_en,
  input  logic [NUM_DAC*DATA_W-1:0] DAC_thrsh,
  input  logic [NUM_DAC-1:0]        DAC_thrsh_pol,
  output logic [NUM_DAC-1:0]        DAC_thrsh_out,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic                      DAC_SYNC,
  output logic                      DAC_SCLK,
  output logic [NUM_DAC-1:0]        DAC_DIN
);

  localparam int FRAME_W = frame_w(CMD_W, DATA_W);
  localparam int CH_W    = (NUM_DAC > 1) ? $clog2(NUM_DAC) : 1;
  localparam int X_W     = DATA_W + 2;
  localparam int S_W     = DATA_W + 16;
  localparam int P_W     = DATA_W + 20;

  logic [1:0]                state;
  logic [1:0]                phase;
  logic [CH_W-1:0]           ch;
  logic [NUM_DAC*DATA_W-1:0] samp_q, thr_q;
  logic [NUM_DAC-1:0]        en_q, pol_q;
  logic [3*NUM_DAC-1:0]      gain_q;
  logic signed [S_W-1:0]     hpf_state [NUM_DAC];
  logic signed [X_W-1:0]     x_c, st_top, diff_c, diff_q;
  logic signed [X_W:0]       diff_wide;
  logic signed [P_W-1:0]     prod_q;
  logic signed [17:0]        coef_ext;
  logic signed [DATA_W-1:0]  y_c;
  logic [DATA_W-1:0]         samp_c, y_off, thr_c, s_c, data_c;
  logic [FRAME_W-1:0]        word_c;
  logic                      thr_hit, last_ch, start_q, load, ser_gap, ser_done;

  // Stage 1 works in a 2-bit-extended signed domain against the top of the filter state.
  always_comb begin
    samp_c    = samp_q[ch*DATA_W +: DATA_W];
    x_c       = {~samp_c[DATA_W-1], samp_c[DATA_W-2:0], 2'b00};
    st_top    = hpf_state[ch][S_W-1 -: X_W];
    diff_wide = {x_c[X_W-1], x_c} - {st_top[X_W-1], st_top};
    if (diff_wide[X_W] != diff_wide[X_W-1])
      diff_c = diff_wide[X_W] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
    else
      diff_c = diff_wide[X_W-1:0];
  end

  assign coef_ext = {1'b0, HPF_coefficient, 1'b0};

  always_comb begin
    y_c     = HPF_en ? diff_q[X_W-1:2] : {~samp_c[DATA_W-1], samp_c[DATA_W-2:0]};
    y_off   = {~y_c[DATA_W-1], y_c[DATA_W-2:0]};
    thr_c   = thr_q[ch*DATA_W +: DATA_W];
    thr_hit = pol_q[ch] ? (y_off >= thr_c) : (y_off <= thr_c);
    s_c     = DATA_W'(shift_sat(sat_sub(int'(y_c), int'({noise_suppress, 4'b0000})),
                                int'(gain_q[ch*3 +: 3]), DATA_W));
    data_c  = en_q[ch] ? {~s_c[DATA_W-1], s_c[DATA_W-2:0]} : DATA_W'(midscale(DATA_W));
    word_c  = {{CMD_W{1'b0}}, data_c};
  end

  assign load    = (state == ST_PROC) && (phase == 2'd2);
  assign last_ch = (ch == CH_W'(NUM_DAC - 1));

  // Frame sequencer; channels share the pipeline strictly one after another.
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      sample_ready  <= 1'b1;
      phase         <= 2'd0;
      ch            <= '0;
      samp_q        <= '0;
      thr_q         <= '0;
      en_q          <= '0;
      pol_q         <= '0;
      gain_q        <= '0;
      diff_q        <= '0;
      prod_q        <= '0;
      start_q       <= 1'b0;
      DAC_thrsh_out <= '0;
      for (int i = 0; i < NUM_DAC; i++) hpf_state[i] <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE: if (sample_valid) begin
          samp_q       <= DAC_input;
          en_q         <= DAC_en;
          gain_q       <= gain;
          thr_q        <= DAC_thrsh;
          pol_q        <= DAC_thrsh_pol;
          state        <= ST_PROC;
          sample_ready <= 1'b0;
          phase        <= 2'd0;
          ch           <= '0;
        end
        ST_PROC: case (phase)
          2'd0: begin
            diff_q <= diff_c;
            phase  <= 2'd1;
          end
          2'd1: begin
            prod_q <= diff_q * coef_ext;
            phase  <= 2'd2;
          end
          default: begin
            hpf_state[ch]     <= hpf_state[ch] + S_W'(prod_q >>> 3);
            DAC_thrsh_out[ch] <= en_q[ch] & thr_hit;
            phase             <= 2'd0;
            if (last_ch) begin
              state   <= ST_SHIFT;
              start_q <= 1'b1;
            end else begin
              ch <= ch + 1'b1;
            end
          end
        endcase
        ST_SHIFT, ST_GAP: begin
          if (ser_done) begin
            state        <= ST_IDLE;
            sample_ready <= 1'b1;
          end else if (ser_gap) begin
            state <= ST_GAP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) overrun <= 1'b0;
    else if (overrun_clr) overrun <= 1'b0;
    else if (sample_valid && !sample_ready) overrun <= 1'b1;
  end

  dac_spi_serializer #(
    .NUM_DAC (NUM_DAC),
    .FRAME_W (FRAME_W),
    .SCLK_DIV(SCLK_DIV),
    .CH_W    (CH_W)
  ) u_ser (
    .dataclk  (dataclk),
    .reset_n  (reset_n),
    .load     (load),
    .load_ch  (ch),
    .load_word(word_c),
    .start    (start_q),
    .dac_sync (DAC_SYNC),
    .dac_sclk (DAC_SCLK),
    .dac_din  (DAC_DIN),
    .in_gap   (ser_gap),
    .done     (ser_done)
  );

endmodule
